// File: rtl/vend_cu.sv
// Vending machine control unit: coin credit accumulation, price check, vend strobe, change payout.
// Optional VEND_CANCEL_EN adds a cancel input that refunds the whole credit as change.
module vend_cu #(
   parameter int CW         = 8,
   parameter int MAX_CREDIT = 200,
   parameter int CHG_GAP    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          coin_10,
   input  logic          coin_20,
   input  logic          coin_50,
   input  logic          coin_100,
   input  logic          sel,
   input  logic [CW-1:0] price,
`ifdef VEND_CANCEL_EN
   input  logic          cancel,
`endif
   output logic [CW-1:0] credit,
   output logic          coin_en,
   output logic          coin_rej,
   output logic          vend,
   output logic          err_insuf,
   output logic          change_10,
   output logic          busy,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

   localparam int GW = (CHG_GAP > 2) ? $clog2(CHG_GAP) : 1;
   localparam logic [GW-1:0] GAP_LD = GW'(CHG_GAP - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d, base;
   logic [GW-1:0] gap_q, gap_d;
   logic          coin_en_q, coin_en_d, rej_q, rej_d, vend_q, vend_d;
   logic          err_q, err_d, chg_q, chg_d, busy_q, busy_d;
   logic [4:0]    s;
   logic [CW:0]   sum_w;
   logic          coin_any, over, cancel_w;

`ifdef VEND_CANCEL_EN
   assign cancel_w = cancel;
`else
   assign cancel_w = 1'b0;
`endif

   assign s = 5'(coin_10) + 5'({coin_20, 1'b0}) + 5'({coin_50, 1'b0, coin_50})
            + 5'({coin_100, 1'b0, coin_100, 1'b0});
   // One extra bit so the ceiling compare cannot wrap.
   assign sum_w    = {1'b0, credit_q} + (CW+1)'(s);
   assign coin_any = (s != 5'd0);
   assign over     = (sum_w > (CW+1)'(MAX_CREDIT));

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      gap_d    = gap_q;
      base     = credit_q;
      rej_d    = 1'b0;
      err_d    = 1'b0;
      chg_d    = 1'b0;
      case (state_q)
         IDLE, COLLECT: begin
            rej_d = coin_any && over;
            if (coin_any && !over) base = sum_w[CW-1:0];
            if (cancel_w && (state_q == COLLECT)) begin
               state_d  = CHANGE;
               credit_d = base - CW'(1);
               chg_d    = 1'b1;
               gap_d    = GAP_LD;
            end else if (sel && (price != '0) && (credit_q >= price)) begin
               state_d  = VEND;
               credit_d = base - price;
            end else begin
               credit_d = base;
               err_d    = sel;
               state_d  = (base != '0) ? COLLECT : IDLE;
            end
         end
         VEND: begin
            rej_d = coin_any;
            if (credit_q != '0) begin
               state_d  = CHANGE;
               credit_d = credit_q - CW'(1);
               chg_d    = 1'b1;
               gap_d    = GAP_LD;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            rej_d = coin_any;
            // The pulse that emptied the credit was last cycle; leave now.
            if (credit_q == '0) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               credit_d = credit_q - CW'(1);
               chg_d    = 1'b1;
               gap_d    = GAP_LD;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
      endcase
      vend_d    = (state_d == VEND);
      busy_d    = (state_d == VEND) || (state_d == CHANGE);
      coin_en_d = !busy_d && (credit_d != CW'(MAX_CREDIT));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         credit_q  <= '0;
         gap_q     <= '0;
         coin_en_q <= 1'b1;
         rej_q     <= 1'b0;
         vend_q    <= 1'b0;
         err_q     <= 1'b0;
         chg_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         gap_q     <= gap_d;
         coin_en_q <= coin_en_d;
         rej_q     <= rej_d;
         vend_q    <= vend_d;
         err_q     <= err_d;
         chg_q     <= chg_d;
         busy_q    <= busy_d;
      end
   end

   assign credit    = credit_q;
   assign coin_en   = coin_en_q;
   assign coin_rej  = rej_q;
   assign vend      = vend_q;
   assign err_insuf = err_q;
   assign change_10 = chg_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_vend_cu.sv
// Directed bench for vend_cu: each step queues the expected output snapshot, then checks it after the edge.
// Cancel scenarios are compiled in when VEND_CANCEL_EN is defined.
module tb_vend_cu;

   localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_VEND = 2'd2, S_CHANGE = 2'd3;
   // coin vector {coin_100, coin_50, coin_20, coin_10}
   localparam logic [3:0] NC = 4'b0000, C10 = 4'b0001, C20 = 4'b0010, C50 = 4'b0100, C100 = 4'b1000;
   // pulse vector {coin_rej, vend, err_insuf, change_10}
   localparam logic [3:0] P0 = 4'b0000, PREJ = 4'b1000, PVEND = 4'b0100, PERR = 4'b0010, PCHG = 4'b0001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_10 = 1'b0, coin_20 = 1'b0, coin_50 = 1'b0, coin_100 = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] price = 8'd0;
   logic       cancel = 1'b0;
   logic [7:0] credit;
   logic       coin_en, coin_rej, vend, err_insuf, change_10, busy;
   logic [1:0] state_dbg;

   logic [15:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   vend_cu #(.CW(8), .MAX_CREDIT(200), .CHG_GAP(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .coin_10(coin_10), .coin_20(coin_20), .coin_50(coin_50), .coin_100(coin_100),
      .sel(sel), .price(price),
`ifdef VEND_CANCEL_EN
      .cancel(cancel),
`endif
      .credit(credit), .coin_en(coin_en), .coin_rej(coin_rej), .vend(vend),
      .err_insuf(err_insuf), .change_10(change_10), .busy(busy), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // One clock step: drive inputs, queue the expectation, compare after the edge.
   task automatic tick(input logic [3:0] coins, input logic s, input logic [7:0] p, input logic c,
                       input logic [7:0] e_credit, input logic [3:0] e_pulse,
                       input logic [1:0] e_state, input string tag);
      logic        e_busy, e_en;
      logic [15:0] got, exp_v;
      string       t;
      e_busy = (e_state == S_VEND) || (e_state == S_CHANGE);
      e_en   = !e_busy && (e_credit != 8'd200);
      exp_q.push_back({e_credit, e_en, e_pulse, e_busy, e_state});
      tag_q.push_back(tag);
      {coin_100, coin_50, coin_20, coin_10} = coins;
      sel = s;
      price = p;
      cancel = c;
      @(posedge clk);
      #1;
      {coin_100, coin_50, coin_20, coin_10} = NC;
      sel = 1'b0;
      price = 8'd0;
      cancel = 1'b0;
      got = {credit, coin_en, coin_rej, vend, err_insuf, change_10, busy, state_dbg};
      exp_v = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (got === exp_v) n_pass++;
      else $error("FAIL %s: got credit=%0d en/rej/vend/err/chg/busy=%b state=%0d, want credit=%0d en/rej/vend/err/chg/busy=%b state=%0d",
                  t, got[15:8], got[7:2], got[1:0], exp_v[15:8], exp_v[7:2], exp_v[1:0]);
   endtask

   initial begin
      // Reset held two cycles with coins and sel toggling.
      rst_n = 1'b0;
      tick(C50 | C10, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "reset0");
      tick(C100, 1'b1, 8'd1, 1'b1, 8'd0, P0, S_IDLE, "reset1");
      rst_n = 1'b1;
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "idle");

      // Exact payment.
      tick(C50, 1'b0, 8'd0, 1'b0, 8'd5, P0, S_COLLECT, "exact_c50");
      tick(C10, 1'b0, 8'd0, 1'b0, 8'd6, P0, S_COLLECT, "exact_c10");
      tick(NC, 1'b1, 8'd6, 1'b0, 8'd0, PVEND, S_VEND, "exact_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "exact_idle");

      // Overpay: three change pulses four cycles apart; coin and sel during change.
      tick(C100, 1'b0, 8'd0, 1'b0, 8'd10, P0, S_COLLECT, "over_c100");
      tick(NC, 1'b1, 8'd7, 1'b0, 8'd3, PVEND, S_VEND, "over_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd2, PCHG, S_CHANGE, "over_chg1");
      for (int k = 1; k <= 8; k++) begin
         tick((k == 2) ? C10 : NC, (k == 3), 8'd1, 1'b0, 8'(2 - k / 4),
              ((k % 4) == 0) ? PCHG : ((k == 2) ? PREJ : P0), S_CHANGE, $sformatf("over_chg_k%0d", k));
      end
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "over_idle");

      // Insufficient and invalid selects; comparison uses pre-edge credit.
      tick(NC, 1'b1, 8'd0, 1'b0, 8'd0, PERR, S_IDLE, "sel_p0_idle");
      tick(C50, 1'b0, 8'd0, 1'b0, 8'd5, P0, S_COLLECT, "insuf_c50");
      tick(NC, 1'b1, 8'd6, 1'b0, 8'd5, PERR, S_COLLECT, "insuf_p6");
      tick(NC, 1'b1, 8'd0, 1'b0, 8'd5, PERR, S_COLLECT, "insuf_p0");
      tick(C10, 1'b1, 8'd7, 1'b0, 8'd6, PERR, S_COLLECT, "insuf_coin_sel");
      tick(NC, 1'b1, 8'd6, 1'b0, 8'd0, PVEND, S_VEND, "insuf_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "insuf_idle");

      // Credit ceiling.
      for (int i = 1; i <= 19; i++)
         tick(C100, 1'b0, 8'd0, 1'b0, 8'(10 * i), P0, S_COLLECT, $sformatf("fill_%0d", i));
      tick(C50, 1'b0, 8'd0, 1'b0, 8'd195, P0, S_COLLECT, "fill_195");
      tick(C50 | C20, 1'b0, 8'd0, 1'b0, 8'd195, PREJ, S_COLLECT, "ovf_rej");
      tick(C50, 1'b0, 8'd0, 1'b0, 8'd200, P0, S_COLLECT, "at_max");
      tick(C10, 1'b0, 8'd0, 1'b0, 8'd200, PREJ, S_COLLECT, "max_rej");
      tick(NC, 1'b1, 8'd200, 1'b0, 8'd0, PVEND, S_VEND, "max_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "max_idle");

      // Simultaneous coin and select.
      tick(C20, 1'b0, 8'd0, 1'b0, 8'd2, P0, S_COLLECT, "sim_c20");
      tick(C20, 1'b1, 8'd3, 1'b0, 8'd4, PERR, S_COLLECT, "sim_short");
      tick(C10, 1'b1, 8'd4, 1'b0, 8'd1, PVEND, S_VEND, "sim_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, PCHG, S_CHANGE, "sim_chg");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "sim_idle");

      // Reset in the middle of change payout.
      tick(C100, 1'b0, 8'd0, 1'b0, 8'd10, P0, S_COLLECT, "mid_c100");
      tick(NC, 1'b1, 8'd5, 1'b0, 8'd5, PVEND, S_VEND, "mid_vend");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd4, PCHG, S_CHANGE, "mid_chg1");
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd4, P0, S_CHANGE, "mid_gap");
      rst_n = 1'b0;
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "mid_reset");
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++)
         tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, $sformatf("mid_quiet_%0d", k));

`ifdef VEND_CANCEL_EN
      // Cancel ignored in IDLE; cancel beats sel; reset after the fifth refund pulse.
      tick(NC, 1'b0, 8'd0, 1'b1, 8'd0, P0, S_IDLE, "cancel_idle");
      tick(C100, 1'b0, 8'd0, 1'b0, 8'd10, P0, S_COLLECT, "can_c100");
      tick(C20, 1'b0, 8'd0, 1'b0, 8'd12, P0, S_COLLECT, "can_c20");
      tick(NC, 1'b1, 8'd1, 1'b1, 8'd11, PCHG, S_CHANGE, "can_chg1");
      for (int k = 1; k <= 16; k++)
         tick(NC, 1'b0, 8'd0, 1'b0, 8'(11 - k / 4), ((k % 4) == 0) ? PCHG : P0, S_CHANGE,
              $sformatf("can_chg_k%0d", k));
      rst_n = 1'b0;
      tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, "can_reset");
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++)
         tick(NC, 1'b0, 8'd0, 1'b0, 8'd0, P0, S_IDLE, $sformatf("can_quiet_%0d", k));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
